// File: rtl/lcd_pkg.sv
// Shared constants for the PCD8544-style LCD receiver: geometry, opcode masks/values,
// display-mode encodings and framebuffer address helpers.
package lcd_pkg;

  localparam int COLS     = 84;
  localparam int BANKS    = 6;
  localparam int FB_BYTES = COLS * BANKS;

  localparam int X_W    = 7;
  localparam int Y_W    = 3;
  localparam int ADDR_W = 9;

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BANKS - 1);

  typedef enum logic [1:0] {
    DISP_BLANK   = 2'b00,
    DISP_ALL_ON  = 2'b01,
    DISP_NORMAL  = 2'b10,
    DISP_INVERSE = 2'b11
  } disp_mode_e;

  // A command matches an opcode when (byte & MSK_*) == OP_*.
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] MSK_FUNC = 8'hF8, OP_FUNC = 8'h20;
  localparam logic [7:0] MSK_DISP = 8'hFA, OP_DISP = 8'h08;
  localparam logic [7:0] MSK_SETY = 8'hF8, OP_SETY = 8'h40;
  localparam logic [7:0] MSK_SETX = 8'h80, OP_SETX = 8'h80;
  localparam logic [7:0] MSK_TC   = 8'hFC, OP_TC   = 8'h04;
  localparam logic [7:0] MSK_BIAS = 8'hF8, OP_BIAS = 8'h10;
  localparam logic [7:0] MSK_VOP  = 8'h80, OP_VOP  = 8'h80;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/lcd_spi_sync.sv
// Synchronises the slow serial-link inputs into the clock domain and flags
// rising edges of the synchronised sclk.
module lcd_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic Reset,
  input  logic sclk,
  input  logic sce,
  input  logic mosi,
  input  logic dc,
  input  logic rst,
  output logic sclk_rise,
  output logic sce_s,
  output logic mosi_s,
  output logic dc_s,
  output logic rst_s
);

  logic [SYNC_STAGES-1:0] sclk_q, sce_q, mosi_q, dc_q, rst_q;
  logic                   sclk_prev;

  always_ff @(posedge clock) begin
    if (!Reset) begin
      // Active-low link inputs restart in their idle (deasserted) level.
      sclk_q    <= '0;
      sce_q     <= '1;
      mosi_q    <= '0;
      dc_q      <= '0;
      rst_q     <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sce_q     <= {sce_q[SYNC_STAGES-2:0], sce};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      dc_q      <= {dc_q[SYNC_STAGES-2:0], dc};
      rst_q     <= {rst_q[SYNC_STAGES-2:0], rst};
      sclk_prev <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev;
  assign sce_s     = sce_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign dc_s      = dc_q[SYNC_STAGES-1];
  assign rst_s     = rst_q[SYNC_STAGES-1];

endmodule

// File: rtl/lcd_spi_receiver.sv
// Receive end of the 3-wire LCD link: byte deserialiser, command decoder,
// auto-incrementing address counters and a read-first framebuffer mirror.
module lcd_spi_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              sce,
  input  logic              dc,
  input  logic              rst,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_is_dat,
  output logic [X_W-1:0]    cur_x,
  output logic [Y_W-1:0]    cur_y,
  output logic              func_pd,
  output logic              func_v,
  output logic              func_h,
  output logic [1:0]        disp_mode,
  output logic [6:0]        vop,
  output logic [2:0]        bias,
  output logic [1:0]        tc,
  output logic              cmd_err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic sclk_rise, sce_s, mosi_s, dc_s, rst_s;

  lcd_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .Reset     (Reset),
    .sclk      (sclk),
    .sce       (sce),
    .mosi      (mosi),
    .dc        (dc),
    .rst       (rst),
    .sclk_rise (sclk_rise),
    .sce_s     (sce_s),
    .mosi_s    (mosi_s),
    .dc_s      (dc_s),
    .rst_s     (rst_s)
  );

  logic [6:0]        shift_q;
  logic [2:0]        bit_cnt;
  logic [7:0]        new_byte;
  logic              byte_done;
  logic              fb_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        mem [FB_BYTES];

  assign new_byte  = {shift_q, mosi_s};
  assign byte_done = sclk_rise && !sce_s && rst_s && (bit_cnt == 3'd7);
  assign fb_we     = byte_done && dc_s && Reset;
  assign wr_addr   = fb_addr(cur_x, cur_y);

  always_ff @(posedge clock) begin
    if (!Reset || !rst_s) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_is_dat <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      func_pd     <= 1'b1;
      func_v      <= 1'b0;
      func_h      <= 1'b0;
      disp_mode   <= DISP_BLANK;
      vop         <= '0;
      bias        <= '0;
      tc          <= '0;
      // The display reset line leaves the sticky error flag alone.
      if (!Reset) cmd_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sce_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= new_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        byte_valid  <= 1'b1;
        byte_data   <= new_byte;
        byte_is_dat <= dc_s;
        if (dc_s) begin
          if (!func_v) begin
            if (cur_x == X_LAST) begin
              cur_x <= '0;
              cur_y <= (cur_y == Y_LAST) ? '0 : cur_y + 3'd1;
            end else begin
              cur_x <= cur_x + 7'd1;
            end
          end else begin
            if (cur_y == Y_LAST) begin
              cur_y <= '0;
              cur_x <= (cur_x == X_LAST) ? '0 : cur_x + 7'd1;
            end else begin
              cur_y <= cur_y + 3'd1;
            end
          end
        end else if (new_byte == OP_NOP) begin
        end else if ((new_byte & MSK_FUNC) == OP_FUNC) begin
          {func_pd, func_v, func_h} <= new_byte[2:0];
        end else if (!func_h) begin
          if ((new_byte & MSK_DISP) == OP_DISP) begin
            disp_mode <= {new_byte[2], new_byte[0]};
          end else if ((new_byte & MSK_SETY) == OP_SETY) begin
            if (new_byte[2:0] < Y_W'(BANKS)) cur_y <= new_byte[2:0];
            else cmd_err <= 1'b1;
          end else if ((new_byte & MSK_SETX) == OP_SETX) begin
            if (new_byte[6:0] < X_W'(COLS)) cur_x <= new_byte[6:0];
            else cmd_err <= 1'b1;
          end else begin
            cmd_err <= 1'b1;
          end
        end else begin
          if ((new_byte & MSK_TC) == OP_TC) tc <= new_byte[1:0];
          else if ((new_byte & MSK_BIAS) == OP_BIAS) bias <= new_byte[2:0];
          else if ((new_byte & MSK_VOP) == OP_VOP) vop <= new_byte[6:0];
          else cmd_err <= 1'b1;
        end
      end
    end
  end

  // Framebuffer contents survive both resets.
  always_ff @(posedge clock) begin
    if (fb_we) mem[wr_addr] <= new_byte;
  end

  always_ff @(posedge clock) begin
    if (!Reset) rd_data <= '0;
    else if (rd_addr < ADDR_W'(FB_BYTES)) rd_data <= mem[rd_addr];
    else rd_data <= '0;
  end

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Directed + randomised bench for lcd_spi_receiver against a behavioural display model.
module tb_lcd_spi_receiver;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, sce = 1'b1, dc = 1'b0, rst = 1'b1;
  logic [8:0] rd_addr = '0;
  logic       byte_valid, byte_is_dat, func_pd, func_v, func_h, cmd_err;
  logic [7:0] byte_data, rd_data;
  logic [6:0] cur_x, vop;
  logic [2:0] cur_y, bias;
  logic [1:0] disp_mode, tc;

  always #5 clock = ~clock;

  lcd_spi_receiver dut (
    .clock(clock), .Reset(Reset), .sclk(sclk), .mosi(mosi), .sce(sce), .dc(dc),
    .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_dat(byte_is_dat), .cur_x(cur_x), .cur_y(cur_y), .func_pd(func_pd),
    .func_v(func_v), .func_h(func_h), .disp_mode(disp_mode), .vop(vop),
    .bias(bias), .tc(tc), .cmd_err(cmd_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  // Reference model: display state as plain integers, framebuffer as a flat array.
  int m_x, m_y, m_pd, m_v, m_h, m_mode, m_vop, m_bias, m_tc, m_err, m_bytes;
  int m_mem[504];

  // Byte-pulse monitor: counts pulses and snapshots outputs at each one.
  int         bv_count = 0;
  logic [7:0] bv_data = '0, bv_rd = '0;
  logic       bv_dat = 1'b0;

  always @(negedge clock) begin
    if (byte_valid) begin
      bv_count++;
      bv_data = byte_data;
      bv_dat  = byte_is_dat;
      bv_rd   = rd_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset(input bit full);
    m_x = 0; m_y = 0; m_pd = 1; m_v = 0; m_h = 0;
    m_mode = 0; m_vop = 0; m_bias = 0; m_tc = 0;
    if (full) m_err = 0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    m_bytes++;
    if (b == 8'h00) return;
    if (b[7:3] == 5'b00100) begin
      m_pd = b[2]; m_v = b[1]; m_h = b[0];
      return;
    end
    if (m_h == 0) begin
      if (b[7:3] == 5'b00001 && b[1] == 1'b0) m_mode = {b[2], b[0]};
      else if (b[7:3] == 5'b01000) begin
        if (b[2:0] < 6) m_y = b[2:0]; else m_err = 1;
      end else if (b[7]) begin
        if (b[6:0] < 84) m_x = b[6:0]; else m_err = 1;
      end else m_err = 1;
    end else begin
      if (b[7:2] == 6'b000001) m_tc = b[1:0];
      else if (b[7:3] == 5'b00010) m_bias = b[2:0];
      else if (b[7]) m_vop = b[6:0];
      else m_err = 1;
    end
  endtask

  // Address advance as a linear walk: row-major when V=0, column-major when V=1.
  task automatic model_data(input logic [7:0] b);
    int lin;
    m_bytes++;
    m_mem[m_y * 84 + m_x] = b;
    if (m_v == 0) begin
      lin = (m_y * 84 + m_x + 1) % 504;
      m_y = lin / 84; m_x = lin % 84;
    end else begin
      lin = (m_x * 6 + m_y + 1) % 504;
      m_x = lin / 6; m_y = lin % 6;
    end
  endtask

  // sclk high and low phases are 4 clocks each, above the 3-clock minimum.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic d);
    sce = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i]; dc = d;
      tick(4); sclk = 1'b1;
      tick(4); sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, 8, d);
    sce = 1'b1;
    tick(4);
    if (d) model_data(b); else model_cmd(b);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".cur_x"}, cur_x, m_x);
    chk({tag, ".cur_y"}, cur_y, m_y);
    chk({tag, ".func_pd"}, func_pd, m_pd);
    chk({tag, ".func_v"}, func_v, m_v);
    chk({tag, ".func_h"}, func_h, m_h);
    chk({tag, ".disp_mode"}, disp_mode, m_mode);
    chk({tag, ".vop"}, vop, m_vop);
    chk({tag, ".bias"}, bias, m_bias);
    chk({tag, ".tc"}, tc, m_tc);
    chk({tag, ".cmd_err"}, cmd_err, m_err);
    chk({tag, ".bytes"}, bv_count, m_bytes);
  endtask

  task automatic read_chk(input int a, input int exp);
    rd_addr = 9'(a);
    tick(2);
    chk($sformatf("rd_data[%0d]", a), rd_data, exp);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 504; a++) begin
      rd_addr = 9'(a);
      tick(2);
      chk($sformatf("%s.mem[%0d]", tag, a), rd_data, m_mem[a]);
    end
  endtask

  int         cnt0, sx;
  logic [7:0] rb;

  initial begin
    m_bytes = 0;
    model_reset(1);
    foreach (m_mem[i]) m_mem[i] = 0;

    // Block reset state.
    tick(5);
    check_regs("reset");
    chk("reset.byte_valid", byte_valid, 0);
    chk("reset.byte_data", byte_data, 0);
    chk("reset.rd_data", rd_data, 0);
    Reset = 1'b1;
    tick(5);

    // Function set / contrast / display control sequence.
    send_byte(8'h21, 1'b0);
    chk("seq.func_h", func_h, 1);
    send_byte(8'h90, 1'b0);
    chk("seq.vop", vop, 7'h10);
    send_byte(8'h20, 1'b0);
    send_byte(8'h0C, 1'b0);
    chk("seq.func_h0", func_h, 0);
    chk("seq.func_pd0", func_pd, 0);
    chk("seq.disp_mode", disp_mode, 2'b10);
    chk("seq.cmd_err", cmd_err, 0);
    check_regs("seq");

    // Full-screen fill: addressing wraps back to the origin.
    send_byte(8'h80, 1'b0);
    send_byte(8'h40, 1'b0);
    cnt0 = bv_count;
    for (int i = 0; i < 504; i++) send_byte(8'h00, 1'b1);
    chk("fill.count", bv_count - cnt0, 504);
    chk("fill.cur_x", cur_x, 0);
    chk("fill.cur_y", cur_y, 0);
    check_mem("fill");
    read_chk(504, 0);
    read_chk(511, 0);

    // Two data bytes; read of address 1 during its write sees the old byte.
    send_byte(8'h80, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h30, 1'b1);
    rd_addr = 9'd1;
    send_byte(8'h48, 1'b1);
    chk("rdfirst.old", bv_rd, 8'h00);
    chk("rdfirst.byte_data", bv_data, 8'h48);
    chk("rdfirst.is_dat", bv_dat, 1);
    chk("rdfirst.new", rd_data, 8'h48);
    read_chk(0, 8'h30);
    chk("rdfirst.cur_x", cur_x, 2);

    // Corner write and both wrap directions.
    send_byte(8'hD3, 1'b0);
    send_byte(8'h45, 1'b0);
    send_byte(8'hAA, 1'b1);
    read_chk(503, 8'hAA);
    chk("corner.cur_x", cur_x, 0);
    chk("corner.cur_y", cur_y, 0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h45, 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("vwrap.cur_y", cur_y, 0);
    chk("vwrap.cur_x", cur_x, 1);
    check_regs("vwrap");

    // Partial byte aborted by sce.
    cnt0 = bv_count;
    send_bits(8'hF8, 5, 1'b1);
    sce = 1'b1;
    tick(6);
    chk("partial.none", bv_count, cnt0);
    send_byte(8'h55, 1'b1);
    chk("partial.one", bv_count, cnt0 + 1);
    chk("partial.byte_data", bv_data, 8'h55);

    // Randomised mix of commands and data.
    for (int i = 0; i < 60; i++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 4) send_byte(rb, 1'b0);
      else send_byte(rb, 1'b1);
    end
    check_regs("rand");
    check_mem("rand");

    // Out-of-range X is rejected.
    send_byte(8'h20, 1'b0);
    sx = m_x;
    send_byte(8'hD4, 1'b0);
    chk("badx.cur_x", cur_x, sx);
    chk("badx.cmd_err", cmd_err, 1);

    // Display reset mid-byte: registers reset, error kept, partial byte discarded.
    send_bits(8'hF0, 3, 1'b1);
    rst = 1'b0;
    tick(6);
    model_reset(0);
    check_regs("rst");
    chk("rst.func_pd", func_pd, 1);
    chk("rst.cmd_err", cmd_err, 1);
    rst = 1'b1;
    tick(6);
    send_bits(8'hC3, 8, 1'b1);
    sce = 1'b1;
    tick(4);
    model_data(8'hC3);
    check_regs("after_rst");
    read_chk(0, 8'hC3);

    // Block reset clears the error but not the framebuffer.
    Reset = 1'b0;
    tick(4);
    model_reset(1);
    chk("breset.cmd_err", cmd_err, 0);
    check_regs("breset");
    Reset = 1'b1;
    tick(4);
    read_chk(0, 8'hC3);
    read_chk(503, m_mem[503]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
